// File: rtl/risc8_io_pkg.sv
// rtl/risc8_io_pkg.sv - shared definitions for the risc8 peripheral IO bus
package risc8_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } io_state_t;

    localparam int IO_ADDR_W = 7;
    localparam int IO_DATA_W = 8;

    // Returned on a read that no slave answered in time
    localparam logic [IO_DATA_W-1:0] IO_RDATA_DEFAULT = 8'hFF;

endpackage

// File: rtl/risc8_io_rdmux.sv
// rtl/risc8_io_rdmux.sv - OR-combines slave read responses and flags collisions
module risc8_io_rdmux
    import risc8_io_pkg::*;
#(
    parameter int NPERIPH = 4
) (
    input  logic [IO_DATA_W*NPERIPH-1:0] io_rdata,
    input  logic [NPERIPH-1:0]           io_valid,
    output logic [IO_DATA_W-1:0]         rdata,
    output logic                         any_valid,
    output logic                         multi_valid
);

    logic seen;

    // Only slices whose valid bit is set contribute; a second valid marks a collision
    always_comb begin
        rdata       = '0;
        multi_valid = 1'b0;
        seen        = 1'b0;
        for (int i = 0; i < NPERIPH; i++) begin
            if (io_valid[i]) begin
                rdata = rdata | io_rdata[IO_DATA_W*i +: IO_DATA_W];
                if (seen) begin
                    multi_valid = 1'b1;
                end
                seen = 1'b1;
            end
        end
        any_valid = |io_valid;
    end

endmodule

// File: rtl/risc8_io_arbiter.sv
// rtl/risc8_io_arbiter.sv - two-master arbiter for the risc8 peripheral IO bus
module risc8_io_arbiter
    import risc8_io_pkg::*;
#(
    parameter int NPERIPH = 4,
    parameter int TIMEOUT = 7
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         m0_req,
    input  logic                         m0_we,
    input  logic [IO_ADDR_W-1:0]         m0_addr,
    input  logic [IO_DATA_W-1:0]         m0_wdata,
    output logic                         m0_done,
    output logic [IO_DATA_W-1:0]         m0_rdata,
    output logic                         m0_err,

    input  logic                         m1_req,
    input  logic                         m1_we,
    input  logic [IO_ADDR_W-1:0]         m1_addr,
    input  logic [IO_DATA_W-1:0]         m1_wdata,
    output logic                         m1_done,
    output logic [IO_DATA_W-1:0]         m1_rdata,
    output logic                         m1_err,

    output logic                         io_ren,
    output logic                         io_wen,
    output logic [IO_ADDR_W-1:0]         io_addr,
    output logic [IO_DATA_W-1:0]         io_wdata,
    input  logic [IO_DATA_W*NPERIPH-1:0] io_rdata,
    input  logic [NPERIPH-1:0]           io_valid,

    output logic                         busy
);

    logic [IO_DATA_W-1:0] mux_rdata;
    logic                 any_valid;
    logic                 multi_valid;

    risc8_io_rdmux #(
        .NPERIPH (NPERIPH)
    ) u_rdmux (
        .io_rdata    (io_rdata),
        .io_valid    (io_valid),
        .rdata       (mux_rdata),
        .any_valid   (any_valid),
        .multi_valid (multi_valid)
    );

    io_state_t            state;
    logic                 last_grant;
    logic                 owner;
    logic                 owner_we;
    logic [7:0]           wait_cnt;

    logic                 grant_sel;
    logic                 sel_we;
    logic [IO_ADDR_W-1:0] sel_addr;
    logic [IO_DATA_W-1:0] sel_wdata;

    logic                 fin;
    logic                 fin_err;
    logic                 fin_upd;
    logic [IO_DATA_W-1:0] fin_rdata;

    // Winner selection: a lone requester wins, a tie goes to whoever was not granted last
    always_comb begin
        grant_sel = (m0_req && m1_req) ? ~last_grant : m1_req;
        sel_we    = grant_sel ? m1_we    : m0_we;
        sel_addr  = grant_sel ? m1_addr  : m0_addr;
        sel_wdata = grant_sel ? m1_wdata : m0_wdata;
    end

    // Completion decode: writes finish after the strobe, reads on valid or timeout
    always_comb begin
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_upd   = 1'b0;
        fin_rdata = mux_rdata;
        case (state)
            ST_ACCESS: begin
                fin = owner_we;
            end
            ST_WAIT: begin
                if (any_valid) begin
                    fin     = 1'b1;
                    fin_err = multi_valid;
                    fin_upd = 1'b1;
                end else if (wait_cnt == 8'(TIMEOUT)) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    fin_upd   = 1'b1;
                    fin_rdata = IO_RDATA_DEFAULT;
                end
            end
            default: begin
                fin = 1'b0;
            end
        endcase
    end

    // Transaction FSM with registered bus strobes and per-master completion outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            owner_we   <= 1'b0;
            wait_cnt   <= '0;
            io_ren     <= 1'b0;
            io_wen     <= 1'b0;
            io_addr    <= '0;
            io_wdata   <= '0;
            busy       <= 1'b0;
            m0_done    <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_done    <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            io_ren  <= 1'b0;
            io_wen  <= 1'b0;
            m0_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_done <= 1'b0;
            m1_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        owner_we   <= sel_we;
                        io_addr    <= sel_addr;
                        io_wdata   <= sel_wdata;
                        io_ren     <= ~sel_we;
                        io_wen     <= sel_we;
                        busy       <= 1'b1;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!owner_we) begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!fin) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (fin) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                if (!owner) begin
                    m0_done <= 1'b1;
                    m0_err  <= fin_err;
                    if (fin_upd) begin
                        m0_rdata <= fin_rdata;
                    end
                end else begin
                    m1_done <= 1'b1;
                    m1_err  <= fin_err;
                    if (fin_upd) begin
                        m1_rdata <= fin_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_risc8_io_arbiter.sv
// tb/tb_risc8_io_arbiter.sv - scoreboard bench for risc8_io_arbiter
module tb_risc8_io_arbiter;

    localparam int NP = 4;
    localparam int TO = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [6:0]    m0_addr, m1_addr;
    logic [7:0]    m0_wdata, m1_wdata;
    logic          m0_done, m0_err, m1_done, m1_err;
    logic [7:0]    m0_rdata, m1_rdata;
    logic          io_ren, io_wen, busy;
    logic [6:0]    io_addr;
    logic [7:0]    io_wdata;
    logic [8*NP-1:0] io_rdata;
    logic [NP-1:0] io_valid;

    risc8_io_arbiter #(.NPERIPH(NP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .io_ren(io_ren), .io_wen(io_wen), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_valid(io_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    wire [1:0] done_v = {m1_done, m0_done};
    wire [1:0] err_v  = {m1_err, m0_err};
    logic [7:0] rd_v [2];
    assign rd_v[0] = m0_rdata;
    assign rd_v[1] = m1_rdata;

    // Slave address map used by both the slave model and the reference model
    function automatic logic [3:0] smask(logic [6:0] a);
        if (a == 7'h4F) return 4'b0100;
        if (a == 7'h70) return 4'b0011;
        if (a[6:4] == 3'd1) return 4'b0000;
        return 4'b0001 << a[1:0];
    endfunction

    function automatic logic [7:0] sdata(int i, logic [6:0] a);
        if (a == 7'h4F) return 8'h5A;
        if (a == 7'h70) return (i == 0) ? 8'h0F : 8'hF0;
        return {1'b0, a} + 8'(i * 29);
    endfunction

    function automatic int sdelay(logic [6:0] a);
        if (a == 7'h4F || a == 7'h70) return 0;
        return int'(a[3:2]);
    endfunction

    // Requester bookkeeping shared by stimulus and monitor
    logic       pend [2];
    logic       p_we [2];
    logic [6:0] p_addr [2];
    logic [7:0] p_wdata [2];
    int         p_cyc [2];

    typedef struct {
        int         m;
        int         due;
        logic       we;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t expq[$];
    int   grant_log[$];

    task automatic issue(int m, logic we, logic [6:0] a, logic [7:0] d);
        if (m == 0) begin
            m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
        end
        p_we[m] = we; p_addr[m] = a; p_wdata[m] = d; p_cyc[m] = cyc; pend[m] = 1'b1;
    endtask

    task automatic drop(int m);
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    task automatic wait_done(int m);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (done_v[m]) got = 1'b1;
        end
        chk($sformatf("wait_done_m%0d", m), 64'(got), 64'd1);
        drop(m);
    endtask

    task automatic rand_master(int m, int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            issue(m, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
            wait_done(m);
        end
    endtask

    // Slave model: answers a read strobe after the address-dependent delay
    logic       s_pend;
    logic [6:0] s_addr;
    int         s_dly;
    initial begin
        logic [3:0] sm;
        io_valid = '0;
        io_rdata = '0;
        s_pend   = 1'b0;
        s_addr   = '0;
        s_dly    = 0;
        forever begin
            @(negedge clk);
            io_valid = '0;
            io_rdata = 32'($urandom);
            if (!reset) begin
                s_pend = 1'b0;
            end else begin
                if (s_pend) begin
                    if (s_dly == 0) begin
                        sm = smask(s_addr);
                        io_valid = sm;
                        for (int i = 0; i < NP; i++)
                            if (sm[i]) io_rdata[8*i +: 8] = sdata(i, s_addr);
                        s_pend = 1'b0;
                    end else begin
                        s_dly--;
                    end
                end
                if (io_ren) begin
                    s_pend = 1'b1;
                    s_addr = io_addr;
                    s_dly  = sdelay(io_addr);
                end
            end
        end
    end

    // Monitor: predicts grants and completions at transaction level and checks them
    int         model_last = 1;
    int         last_strobe = -10;
    logic [7:0] held [2];
    initial begin
        exp_t       e;
        logic [3:0] sm;
        logic [7:0] r;
        bit         c0, c1;
        int         w;
        held[0] = 8'h00;
        held[1] = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("reset_outputs", 64'({m0_done, m0_rdata, m0_err, m1_done, m1_rdata, m1_err,
                                          io_ren, io_wen, io_addr, io_wdata, busy}), 64'd0);
                expq.delete();
                model_last  = 1;
                last_strobe = -10;
                held[0] = 8'h00;
                held[1] = 8'h00;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    if (done_v[m]) begin
                        if (expq.size() == 0 || expq[0].m != m) begin
                            chk($sformatf("unexpected_done_m%0d", m), 64'd1, 64'd0);
                        end else begin
                            e = expq.pop_front();
                            if (!e.we) held[m] = e.rdata;
                            chk($sformatf("done_cycle_m%0d", m), 64'(cyc), 64'(e.due));
                            chk($sformatf("done_err_m%0d", m), 64'(err_v[m]), 64'(e.err));
                        end
                    end
                end
                if (expq.size() != 0 && cyc > expq[0].due) begin
                    chk("done_missing", 64'(cyc), 64'(expq[0].due));
                    void'(expq.pop_front());
                end
                chk("rdata_m0", 64'(rd_v[0]), 64'(held[0]));
                chk("rdata_m1", 64'(rd_v[1]), 64'(held[1]));
                if (io_ren || io_wen) begin
                    chk("single_strobe", 64'(io_ren & io_wen), 64'd0);
                    chk("strobe_gap", 64'(cyc - last_strobe > 1), 64'd1);
                    last_strobe = cyc;
                    c0 = pend[0] && (p_cyc[0] < cyc);
                    c1 = pend[1] && (p_cyc[1] < cyc);
                    if (!c0 && !c1) begin
                        chk("spurious_strobe", 64'd1, 64'd0);
                    end else begin
                        w = (c0 && c1) ? ((model_last == 0) ? 1 : 0) : (c1 ? 1 : 0);
                        chk("io_we", 64'(io_wen), 64'(p_we[w]));
                        chk("io_addr", 64'(io_addr), 64'(p_addr[w]));
                        chk("io_wdata", 64'(io_wdata), 64'(p_wdata[w]));
                        e.m  = w;
                        e.we = p_we[w];
                        if (p_we[w]) begin
                            e.due = cyc + 1; e.err = 1'b0; e.rdata = 8'h00;
                        end else begin
                            sm = smask(p_addr[w]);
                            if (sm == 4'b0000) begin
                                e.due = cyc + TO + 2; e.err = 1'b1; e.rdata = 8'hFF;
                            end else begin
                                r = 8'h00;
                                for (int i = 0; i < NP; i++)
                                    if (sm[i]) r = r | sdata(i, p_addr[w]);
                                e.due = cyc + sdelay(p_addr[w]) + 2;
                                e.err = ($countones(sm) > 1);
                                e.rdata = r;
                            end
                        end
                        expq.push_back(e);
                        pend[w]    = 1'b0;
                        model_last = w;
                        grant_log.push_back(w);
                    end
                end
                chk("busy", 64'(busy), 64'(expq.size() != 0));
            end
        end
    end

    initial begin
        logic [3:0] gl;
        pend[0] = 1'b0; pend[1] = 1'b0;
        p_cyc[0] = 0;   p_cyc[1] = 0;
        reset = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

        // Request held through reset: nothing reaches the bus until release
        issue(0, 1'b0, 7'h21, 8'h00);
        repeat (3) @(negedge clk);
        chk("reset_no_ren", 64'(io_ren), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("release_ren", 64'(io_ren), 64'd1);
        wait_done(0);

        @(negedge clk);
        issue(0, 1'b1, 7'h2D, 8'h03);
        wait_done(0);
        chk("wr_err", 64'(m0_err), 64'd0);

        @(negedge clk);
        issue(1, 1'b0, 7'h4F, 8'h00);
        wait_done(1);
        chk("m1_read_data", 64'(m1_rdata), 64'h5A);
        chk("m1_read_err", 64'(m1_err), 64'd0);

        // Continuous contention alternates grants
        @(negedge clk);
        grant_log.delete();
        fork
            begin
                issue(0, 1'b1, 7'h31, 8'hA5); wait_done(0);
                @(negedge clk);
                issue(0, 1'b0, 7'h22, 8'h00); wait_done(0);
            end
            begin
                issue(1, 1'b0, 7'h23, 8'h00); wait_done(1);
                @(negedge clk);
                issue(1, 1'b1, 7'h44, 8'h5C); wait_done(1);
            end
        join
        chk("contention_count", 64'(grant_log.size()), 64'd4);
        gl = 4'b0000;
        foreach (grant_log[i]) gl = {gl[2:0], 1'(grant_log[i])};
        chk("contention_order", 64'(gl), 64'b0101);

        @(negedge clk);
        issue(0, 1'b0, 7'h10, 8'h00);
        wait_done(0);
        chk("timeout_data", 64'(m0_rdata), 64'hFF);
        chk("timeout_err", 64'(m0_err), 64'd1);

        @(negedge clk);
        issue(1, 1'b0, 7'h70, 8'h00);
        wait_done(1);
        chk("multi_data", 64'(m1_rdata), 64'hFF);
        chk("multi_err", 64'(m1_err), 64'd1);

        // Reset while a read is waiting drops it without a completion
        @(negedge clk);
        issue(0, 1'b0, 7'h10, 8'h00);
        repeat (4) @(negedge clk);
        chk("mid_wait_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1 chk("reset_busy_now", 64'(busy), 64'd0);
        m0_req = 1'b0;
        pend[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 7'h22, 8'h00);
        wait_done(0);
        chk("post_reset_err", 64'(m0_err), 64'd0);

        fork
            rand_master(0, 40);
            rand_master(1, 40);
        join

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
